// File: rtl/mult_datapath.sv
// Sequential shift-add multiplier datapath.
// One conditional add-and-shift per clock after a load. Iteration stops early
// once the multiplier register runs out of set bits. Signed operands are
// multiplied as magnitudes, and the product is negated when the signs differ.
module mult_datapath #(
  parameter int DW = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            l_s,
  input  logic [DW-1:0]   multiplicand,
  input  logic [DW-1:0]   multiplier,
  input  logic            signed_mode,
  output logic [2*DW-1:0] product,
  output logic            done
);

  localparam int CW = $clog2(DW) + 1;

  logic [2*DW-1:0] mcand_q, mcand_d;
  logic [DW-1:0]   mplier_q, mplier_d;
  logic [2*DW-1:0] acc_q, acc_d;
  logic [CW-1:0]   count_q, count_d;
  logic            neg_q, neg_d;
  logic            busy_q, busy_d;
  logic [2*DW-1:0] product_q, product_d;
  logic            done_q, done_d;

  logic [DW-1:0]   mag_a, mag_b;
  logic            finish;

  // Operand magnitudes. -2^(DW-1) maps to 2^(DW-1), which still fits in DW unsigned bits.
  always_comb begin
    mag_a = multiplicand;
    mag_b = multiplier;
    if (signed_mode && multiplicand[DW-1]) mag_a = '0 - multiplicand;
    if (signed_mode && multiplier[DW-1])   mag_b = '0 - multiplier;
  end

  assign finish = (mplier_q == '0) || (count_q == CW'(DW));

  // Next state: a load takes priority in any state; otherwise step while busy.
  always_comb begin
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    count_d   = count_q;
    neg_d     = neg_q;
    busy_d    = busy_q;
    product_d = product_q;
    done_d    = done_q;
    if (l_s) begin
      mcand_d   = {{DW{1'b0}}, mag_a};
      mplier_d  = mag_b;
      neg_d     = signed_mode & (multiplicand[DW-1] ^ multiplier[DW-1]);
      acc_d     = '0;
      count_d   = '0;
      product_d = '0;
      done_d    = 1'b0;
      busy_d    = 1'b1;
    end else if (busy_q) begin
      if (finish) begin
        product_d = neg_q ? ('0 - acc_q) : acc_q;
        done_d    = 1'b1;
        busy_d    = 1'b0;
      end else begin
        if (mplier_q[0]) acc_d = acc_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        count_d  = count_q + CW'(1);
      end
    end
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      count_q   <= '0;
      neg_q     <= 1'b0;
      busy_q    <= 1'b0;
      product_q <= '0;
      done_q    <= 1'b0;
    end else begin
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      count_q   <= count_d;
      neg_q     <= neg_d;
      busy_q    <= busy_d;
      product_q <= product_d;
      done_q    <= done_d;
    end
  end

  assign product = product_q;
  assign done    = done_q;

endmodule
